// File: rtl/sound_sequencer.sv
// sound_sequencer: priority-encoded sound events play square-wave notes of a shared duration,
// with a button-toggled mute state and preemption by higher-priority requests.
module sound_sequencer #(
   parameter int N_EV   = 4,
   parameter int TONE_W = 8,
   parameter int DUR_W  = 16,
   localparam int AW    = $clog2(N_EV)
) (
   input  logic                     clk,
   input  logic                     nRst,
   input  logic [N_EV-1:0]          ev_i,
   input  logic [N_EV*TONE_W-1:0]   tone_i,
   input  logic [DUR_W-1:0]         dur_i,
   input  logic                     button_i,
   output logic                     spk_o,
   output logic                     busy_o,
   output logic [AW-1:0]            active_o,
   output logic                     muted_o
);
   typedef enum logic [1:0] {IDLE, PLAY, MUTED} state_t;

   state_t              state_q, state_d;
   logic                btn_q, btn_d;
   logic                spk_q, spk_d;
   logic                busy_q, busy_d;
   logic                muted_q, muted_d;
   logic [AW-1:0]       active_q, active_d;
   logic [DUR_W-1:0]    dur_cnt_q, dur_cnt_d;
   logic [TONE_W-1:0]   tone_cnt_q, tone_cnt_d;
   logic [TONE_W-1:0]   period_q, period_d;

   logic                btn_rise, sel_any, start;
   logic [AW-1:0]       sel_idx;
   logic [TONE_W-1:0]   sel_tone;

   always_comb begin
      sel_any  = |ev_i;
      sel_idx  = '0;
      sel_tone = '0;
      for (int i = N_EV - 1; i >= 0; i--) begin
         if (ev_i[i]) begin
            sel_idx  = AW'(i);
            sel_tone = tone_i[i*TONE_W +: TONE_W];
         end
      end
      btn_rise = button_i & ~btn_q;
      // a PLAY start is only a preemption when the lowest requested index beats the playing one
      start = sel_any && (dur_i != '0) &&
              ((state_q == IDLE) || ((state_q == PLAY) && (sel_idx < active_q)));
      state_d    = state_q;
      btn_d      = button_i;
      spk_d      = spk_q;
      busy_d     = busy_q;
      muted_d    = muted_q;
      active_d   = active_q;
      dur_cnt_d  = dur_cnt_q;
      tone_cnt_d = tone_cnt_q;
      period_d   = period_q;
      if (btn_rise) begin
         state_d = (state_q == MUTED) ? IDLE : MUTED;
         muted_d = (state_q != MUTED);
         spk_d   = 1'b0;
         busy_d  = 1'b0;
      end else if (start) begin
         state_d    = PLAY;
         period_d   = (sel_tone == '0) ? TONE_W'(1) : sel_tone;
         dur_cnt_d  = dur_i;
         tone_cnt_d = '0;
         active_d   = sel_idx;
         spk_d      = 1'b0;
         busy_d     = 1'b1;
      end else if (state_q == PLAY) begin
         dur_cnt_d = dur_cnt_q - DUR_W'(1);
         if (dur_cnt_q == DUR_W'(1)) begin
            state_d = IDLE;
            spk_d   = 1'b0;
            busy_d  = 1'b0;
         end else if (tone_cnt_q == period_q - TONE_W'(1)) begin
            tone_cnt_d = '0;
            spk_d      = ~spk_q;
         end else begin
            tone_cnt_d = tone_cnt_q + TONE_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q    <= IDLE;
         btn_q      <= 1'b0;
         spk_q      <= 1'b0;
         busy_q     <= 1'b0;
         muted_q    <= 1'b0;
         active_q   <= '0;
         dur_cnt_q  <= '0;
         tone_cnt_q <= '0;
         period_q   <= '0;
      end else begin
         state_q    <= state_d;
         btn_q      <= btn_d;
         spk_q      <= spk_d;
         busy_q     <= busy_d;
         muted_q    <= muted_d;
         active_q   <= active_d;
         dur_cnt_q  <= dur_cnt_d;
         tone_cnt_q <= tone_cnt_d;
         period_q   <= period_d;
      end
   end

   assign spk_o    = spk_q;
   assign busy_o   = busy_q;
   assign active_o = active_q;
   assign muted_o  = muted_q;
endmodule

// File: doc/sound_sequencer.md
SOUND_SEQUENCER -- requirements
Module: sound_sequencer

Interface
REQ-001 Parameter N_EV, default 4, number of prioritised sound-event inputs (>=2).
REQ-002 Parameter TONE_W, default 8, width of each tone half-period value.
REQ-003 Parameter DUR_W, default 16, width of the note-duration value.
REQ-004 Port clk  input  1  single clock; all state on rising edge.
REQ-005 Port nRst  input  1  asynchronous, active-low reset.
REQ-006 Port ev_i  input  N_EV  event request levels; bit 0 highest priority.
REQ-007 Port tone_i  input  N_EV*TONE_W  per-event half-period in cycles; slice k = bits [k*TONE_W +: TONE_W].
REQ-008 Port dur_i  input  DUR_W  note length in cycles, shared by all events, sampled at note start.
REQ-009 Port button_i  input  1  mute-toggle button level.
REQ-010 Port spk_o  output  1  registered square-wave speaker drive.
REQ-011 Port busy_o  output  1  registered; high while a note plays.
REQ-012 Port active_o  output  $clog2(N_EV)  registered index of the playing event.
REQ-013 Port muted_o  output  1  registered; high in MUTED state.

Function
REQ-014 States SHALL be IDLE, PLAY, MUTED.
REQ-015 Button edge: btn_q registers button_i; btn_rise = button_i & ~btn_q; only btn_rise acts, held levels SHALL NOT retoggle.
REQ-016 Any state, btn_rise: IDLE/PLAY -> MUTED; MUTED -> IDLE; takes priority over all events that cycle.
REQ-017 IDLE, no btn_rise, ev_i != 0, dur_i != 0: select lowest set index k, latch period = tone_i slice k (0 treated as 1), load dur_cnt = dur_i, tone_cnt = 0, active_o = k, -> PLAY.
REQ-018 IDLE with dur_i == 0: events ignored, stay IDLE.
REQ-019 PLAY each cycle: dur_cnt decrements; if dur_cnt == 1, -> IDLE next cycle; busy_o therefore high exactly dur_i cycles.
REQ-020 PLAY tone: if tone_cnt == period-1 then tone_cnt <= 0 and spk_o toggles, else tone_cnt increments; spk_o low on every PLAY entry.
REQ-021 Preemption: in PLAY, set bit j < active_o (lowest such j) with dur_i != 0 restarts the note as in REQ-017 for j; same or lower-priority requests ignored.
REQ-022 Preemption SHALL take priority over natural end in the same cycle.
REQ-023 Requests are level-sampled, not queued; a request deasserted before acceptance is lost.
REQ-024 Leaving PLAY (end or mute) SHALL drive spk_o = 0, busy_o = 0 on the following cycle; active_o holds last value.
REQ-025 MUTED: spk_o = 0, busy_o = 0, muted_o = 1; all ev_i ignored; counters frozen.
REQ-026 Latency: request sampled in cycle t -> busy_o = 1 in cycle t+1; first spk_o rise at t+period+1.

Reset
REQ-027 nRst low SHALL immediately force state IDLE (sound enabled), spk_o = 0, busy_o = 0, muted_o = 0, active_o = 0, btn_q = 0, dur_cnt = 0, tone_cnt = 0.
REQ-028 Reset mid-note SHALL abort the note with no residual toggling after release.
REQ-029 button_i held high through reset release SHALL count as a rise on the first clock (btn_q = 0).

Verification
REQ-030 tone slice 2 = 3, dur_i = 12, pulse ev_i = 4'b0100 one cycle -> busy_o high 12 cycles, active_o = 2, spk_o toggles every 3 cycles (2 full periods), then 0.
REQ-031 ev_i = 4'b1010 from IDLE -> active_o = 1; while playing assert bit 0 -> restart with slice 0 period, busy_o continuous, new dur_i cycles counted from restart.
REQ-032 During PLAY, bit 3 asserted while active_o = 1 -> ignored, note ends on schedule.
REQ-033 button_i high 10 cycles during PLAY -> one MUTED entry, spk_o = 0 next cycle; events ignored; second rise -> IDLE, muted_o = 0.
REQ-034 btn_rise and ev_i = 4'b0001 same IDLE cycle -> MUTED, no note; dur_i = 0 with ev_i set -> stays IDLE.
REQ-035 nRst asserted mid-note (async, between edges) -> all outputs 0 at once; after release first event plays normally.
